ps2_frame_receiver: RTL and testbench

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

---
 rtl/ps2_frame_receiver.sv | 154 +++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches the PS/2 lines,
// decodes 11-bit frames and reports good scan codes, parity errors and framing errors.
module ps2_frame_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       PS2_CLOCK_I,
  input  logic       PS2_DATA_I,
  output logic [7:0] PS2_code,
  output logic       PS2_code_ready,
  output logic       parity_error,
  output logic       framing_error
);

  localparam int unsigned FILT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state, state_d;
  logic              clk_meta, clk_sync, data_meta, data_sync;
  logic              filt_clk, filt_prev;
  logic [FILT_W-1:0] filt_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        shift, shift_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic              parity, parity_d;
  logic [7:0]        code_d;
  logic              ready_d, perr_d, ferr_d;
  logic              fall_c, timeout_c;

  // Two-flop synchronizers; idle PS/2 lines are high
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= PS2_CLOCK_I;
      clk_sync  <= clk_meta;
      data_meta <= PS2_DATA_I;
      data_sync <= data_meta;
    end
  end

  // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_sync != filt_clk) begin
        if (filt_cnt == FILT_LAST) begin
          filt_clk <= clk_sync;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FILT_W'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall_c    = filt_prev & ~filt_clk;
  // A falling edge in the timeout cycle still counts as activity
  assign timeout_c = (state != S_IDLE) && (to_cnt == TO_LAST) && !fall_c;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (fall_c || state == S_IDLE) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      shift          <= '0;
      bit_cnt        <= '0;
      parity         <= 1'b0;
      PS2_code       <= 8'h00;
      PS2_code_ready <= 1'b0;
      parity_error   <= 1'b0;
      framing_error  <= 1'b0;
    end else begin
      state          <= state_d;
      shift          <= shift_d;
      bit_cnt        <= bit_cnt_d;
      parity         <= parity_d;
      PS2_code       <= code_d;
      PS2_code_ready <= ready_d;
      parity_error   <= perr_d;
      framing_error  <= ferr_d;
    end
  end

  // Frame decode; at most one outcome pulse per frame
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    parity_d  = parity;
    code_d    = PS2_code;
    ready_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    if (timeout_c) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
    end else if (fall_c) begin
      case (state)
        S_IDLE: begin
          if (!data_sync) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {data_sync, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = data_sync;
          state_d  = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!data_sync) begin
            ferr_d = 1'b1;
          end else if (^{shift, parity}) begin
            code_d  = shift;
            ready_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: a frame-level model predicts every output
// pulse cycle and the held scan code; a compare process checks them each cycle.
module tb_ps2_frame_receiver;

  localparam int TO  = 200;
  localparam int FL  = 4;
  localparam int H   = 20;       // half bit period in system clocks
  localparam int LAT = FL + 3;   // line edge -> registered output (2 sync + filter + register)

  localparam int K_READY = 0;
  localparam int K_PAR   = 1;
  localparam int K_FRM   = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] code;
  } ev_t;

  logic       clk;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] PS2_code;
  logic       PS2_code_ready;
  logic       parity_error;
  logic       framing_error;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         n_ready = 0;
  int         n_par = 0;
  int         n_frm = 0;
  logic [7:0] model_code = 8'h00;
  ev_t        evq[$];

  ps2_frame_receiver #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .CLOCK_50_I     (clk),
    .resetn         (resetn),
    .PS2_CLOCK_I    (ps2_clk),
    .PS2_DATA_I     (ps2_data),
    .PS2_code       (PS2_code),
    .PS2_code_ready (PS2_code_ready),
    .parity_error   (parity_error),
    .framing_error  (framing_error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int at, input int kind, input logic [7:0] code);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.code = code;
    evq.push_back(e);
  endtask

  // Drive the first nbits of a frame; outcome derived from the frame's bit values
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int nbits, input bit expect_timeout);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == nbits - 1) begin
        if (nbits == 11) begin
          if (!stop)            push_ev(cyc + LAT, K_FRM, 8'h00);
          else if (^{d, par})   push_ev(cyc + LAT, K_READY, d);
          else                  push_ev(cyc + LAT, K_PAR, 8'h00);
        end else if (expect_timeout) begin
          push_ev(cyc + LAT + TO, K_FRM, 8'h00);
        end
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    logic exp_r, exp_p, exp_f;
    forever begin
      @(posedge clk);
      #1;
      exp_r = 1'b0;
      exp_p = 1'b0;
      exp_f = 1'b0;
      while (evq.size() > 0 && evq[0].cyc < cyc) void'(evq.pop_front());
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        case (evq[0].kind)
          K_READY: begin exp_r = 1'b1; model_code = evq[0].code; end
          K_PAR:   exp_p = 1'b1;
          default: exp_f = 1'b1;
        endcase
        void'(evq.pop_front());
      end
      chk("ready", 32'(PS2_code_ready), 32'(exp_r));
      chk("parity_error", 32'(parity_error), 32'(exp_p));
      chk("framing_error", 32'(framing_error), 32'(exp_f));
      chk("code", 32'(PS2_code), 32'(model_code));
      if (PS2_code_ready) n_ready++;
      if (parity_error)   n_par++;
      if (framing_error)  n_frm++;
    end
  end

  initial begin
    resetn   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_code", 32'(PS2_code), 32'h00);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    // short low glitch on the clock line while idle
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_pulse", 32'(n_ready + n_par + n_frm), 32'd0);

    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    repeat (H) @(negedge clk);
    chk("f1_code", 32'(PS2_code), 32'h1C);
    chk("f1_ready_count", 32'(n_ready), 32'd1);

    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    repeat (H) @(negedge clk);
    chk("b2b_ready_count", 32'(n_ready), 32'd3);
    chk("b2b_code", 32'(PS2_code), 32'h1C);

    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    repeat (H) @(negedge clk);
    chk("par_count", 32'(n_par), 32'd1);
    chk("par_code_kept", 32'(PS2_code), 32'h1C);

    send_frame(8'h32, 1'b0, 1'b0, 11, 1'b0);
    repeat (H) @(negedge clk);
    chk("stop0_frm_count", 32'(n_frm), 32'd1);
    chk("stop0_par_count", 32'(n_par), 32'd1);
    chk("stop0_code_kept", 32'(PS2_code), 32'h1C);
    send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0);
    repeat (H) @(negedge clk);
    chk("after_frm_code", 32'(PS2_code), 32'h32);

    // clock stops after five data bits
    send_frame(8'h5A, 1'b0, 1'b1, 6, 1'b1);
    repeat (TO + 20) @(negedge clk);
    chk("timeout_frm_count", 32'(n_frm), 32'd2);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    repeat (H) @(negedge clk);
    chk("after_to_code", 32'(PS2_code), 32'h1C);
    chk("after_to_ready", 32'(n_ready), 32'd5);

    // reset in the middle of a frame after four data bits
    send_frame(8'hAA, 1'b1, 1'b1, 5, 1'b0);
    resetn     = 1'b0;
    model_code = 8'h00;
    evq.delete();
    repeat (3) @(negedge clk);
    chk("midrst_code", 32'(PS2_code), 32'h00);
    chk("midrst_pulses", 32'({PS2_code_ready, parity_error, framing_error}), 32'd0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    repeat (H) @(negedge clk);
    chk("post_rst_code", 32'(PS2_code), 32'h1C);
    chk("post_rst_ready", 32'(n_ready), 32'd6);
    chk("total_frm", 32'(n_frm), 32'd2);

    repeat (5) @(negedge clk);
    chk("events_consumed", 32'(evq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
